// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for native-bus initiators: copy FSM states and bus constants.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package mem_copy_dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        RGAP  = 3'd2,
        WRITE = 3'd3,
        WGAP  = 3'd4,
        FIN   = 3'd5
    } dma_state_t;

    // Byte strobes on the native bus: all-zero marks a read, all-ones a full-word write.
    localparam logic [3:0]  WSTRB_READ = 4'b0000;
    localparam logic [3:0]  WSTRB_WORD = 4'b1111;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Byte address of word idx past base; wraps modulo 2^32 by construction.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + idx * WORD_BYTES;
    endfunction

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_bus_txn.sv
// One native-bus transaction: raise valid on launch, hold address/data/strobe until handshake, then drop valid.
// Latency: valid is registered, high the cycle after launch; valid falls the cycle after the handshake.
// Backpressure: waits indefinitely for mem_ready; launch is ignored while a transaction is outstanding.
//
// Ports: clk/resetn; launch + launch_addr/wdata/wstrb from the sequencer;
//        mem_valid/addr/wdata/wstrb/ready to the bus; xfer_done marks the handshake cycle.
module mem_bus_txn
    import mem_copy_dma_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        launch,
    input  logic [31:0] launch_addr,
    input  logic [31:0] launch_wdata,
    input  logic [3:0]  launch_wstrb,
    input  logic        mem_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        xfer_done
);

    assign xfer_done = mem_valid & mem_ready;

    // Request fields load only while idle, so they stay frozen for the whole stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= WSTRB_READ;
        end else if (xfer_done) begin
            mem_valid <= 1'b0;
        end else if (launch && !mem_valid) begin
            mem_valid <= 1'b1;
            mem_addr  <= launch_addr;
            mem_wdata <= launch_wdata;
            mem_wstrb <= launch_wstrb;
        end
    end

endmodule

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: read one word, write it, repeat, over a single native-bus initiator.
// Latency: 6 cycles per word plus 2 (start edge to done) with a one-cycle bus response; done for len=0/errors 2 cycles after start edge.
// Backpressure: each transfer holds until mem_ready; no timeout; start is ignored while not idle.
//
// Ports: clk/resetn; start + src_addr/dst_addr/len request; busy/done/err/count status;
//        mem_valid/ready/addr/wdata/wstrb/rdata native memory initiator.
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] count,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    dma_state_t       state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      buf_q;
    logic [LEN_W-1:0] len_q;
    logic             err_pend;

    logic             req_aligned;
    logic             launch;
    logic [31:0]      launch_addr;
    logic [3:0]       launch_wstrb;
    logic             xfer_done;

    assign req_aligned = is_word_aligned(src_addr) && is_word_aligned(dst_addr);

    // Launch is issued in the same cycle the FSM moves into READ/WRITE so the
    // transaction's registered valid lines up with the new state.
    always_comb begin
        launch       = 1'b0;
        launch_addr  = 32'd0;
        launch_wstrb = WSTRB_READ;
        case (state)
            IDLE: begin
                if (start && req_aligned && (len != '0)) begin
                    launch      = 1'b1;
                    launch_addr = src_addr;
                end
            end
            RGAP: begin
                launch       = 1'b1;
                launch_addr  = word_addr(dst_q, 32'(count));
                launch_wstrb = WSTRB_WORD;
            end
            WGAP: begin
                // count already includes the word just written, so it indexes the next read.
                if (count < len_q) begin
                    launch      = 1'b1;
                    launch_addr = word_addr(src_q, 32'(count));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            src_q    <= 32'd0;
            dst_q    <= 32'd0;
            buf_q    <= 32'd0;
            len_q    <= '0;
            err_pend <= 1'b0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        count <= '0;
                        if (!req_aligned) begin
                            err_pend <= 1'b1;
                            state    <= FIN;
                        end else if (len == '0) begin
                            err_pend <= 1'b0;
                            state    <= FIN;
                        end else begin
                            err_pend <= 1'b0;
                            src_q    <= src_addr;
                            dst_q    <= dst_addr;
                            len_q    <= len;
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    if (xfer_done) begin
                        buf_q <= mem_rdata;
                        state <= RGAP;
                    end
                end
                RGAP: state <= WRITE;
                WRITE: begin
                    if (xfer_done) begin
                        count <= count + LEN_W'(1);
                        state <= WGAP;
                    end
                end
                WGAP: state <= (count < len_q) ? READ : FIN;
                FIN: begin
                    done  <= 1'b1;
                    err   <= err_pend;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_bus_txn u_txn (
        .clk          (clk),
        .resetn       (resetn),
        .launch       (launch),
        .launch_addr  (launch_addr),
        .launch_wdata (buf_q),
        .launch_wstrb (launch_wstrb),
        .mem_ready    (mem_ready),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .xfer_done    (xfer_done)
    );

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: memory responder + transaction-level copy model with per-cycle bus/status compare.
// Latency: n/a.
// Backpressure: responder inserts fixed, random or long stall latencies on mem_ready.
module tb_mem_copy_dma;

    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src_addr = 32'd0;
    logic [31:0]      dst_addr = 32'd0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, err;
    logic [LEN_W-1:0] count;
    logic             mem_valid;
    logic             mem_ready = 1'b0;
    logic [31:0]      mem_addr, mem_wdata;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_rdata = 32'd0;

    mem_copy_dma #(.LEN_W(LEN_W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .err(err), .count(count),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: bus_mem is what the DUT really touches, model_mem is the reference copy result.
    logic [31:0] bus_mem   [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1234};
    endfunction
    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] rd_log[$];

    // Expectations for the copy in flight.
    logic        in_copy = 1'b0;
    logic        exp_err = 1'b0;
    int          exp_count = 0;
    int          exp_lat = -1;
    int          start_cyc = 0;
    int          lat_mode = 0;
    logic        stall_used = 1'b0;

    // Observations captured at done.
    int          done_lat_obs = 0;
    int          count_obs = 0;
    logic        err_obs = 1'b0;
    int          txn_cnt = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vcnt = 0;
    int lat_cur = 1;

    // Memory responder and compare process, both on the falling edge.
    always @(negedge clk) begin
        if (!resetn) begin
            mem_ready = 1'b0;
            vcnt = 0;
        end else begin
            if (mem_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_txn", 32'(mem_valid), 32'd0);
                end else begin
                    check("mem_addr", mem_addr, exp_q[0].addr);
                    check("mem_wstrb", 32'(mem_wstrb), exp_q[0].wr ? 32'hF : 32'h0);
                    if (exp_q[0].wr) check("mem_wdata", mem_wdata, exp_q[0].data);
                end
                if (!mem_ready) begin
                    if (vcnt == 0) begin
                        if (lat_mode == 1) lat_cur = $urandom_range(1, 4);
                        else if (lat_mode == 2 && mem_wstrb != 4'b0000 && !stall_used) begin
                            lat_cur = 50;
                            stall_used = 1'b1;
                        end else lat_cur = 1;
                    end
                    if (vcnt >= lat_cur) begin
                        mem_ready = 1'b1;
                        txn_cnt++;
                        if (mem_wstrb == 4'b0000) begin
                            mem_rdata = bus_rd(mem_addr);
                            rd_log.push_back(mem_addr);
                        end else begin
                            bus_mem[mem_addr] = mem_wdata;
                        end
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end
                    vcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                vcnt = 0;
            end

            if (done) begin
                if (!in_copy) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    check("err_at_done", 32'(err), 32'(exp_err));
                    check("count_at_done", 32'(count), 32'(exp_count));
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("txns_left", 32'(exp_q.size()), 32'd0);
                    if (exp_lat >= 0) check("latency", 32'(cyc - start_cyc + 1), 32'(exp_lat));
                    done_lat_obs = cyc - start_cyc + 1;
                    count_obs = 32'(count);
                    err_obs = err;
                    in_copy = 1'b0;
                end
            end else begin
                check("busy", 32'(busy), 32'(in_copy));
                check("err_without_done", 32'(err), 32'd0);
            end
        end
    end

    // Build the expected transaction list by copying word by word through the model memory.
    task automatic prep(input logic [31:0] s, input logic [31:0] d, input int n, input int mode);
        logic [31:0] dat;
        txn_t t;
        exp_err = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
        exp_count = exp_err ? 0 : n;
        exp_lat = (mode == 0) ? 6 * exp_count + 2 : -1;
        lat_mode = mode;
        stall_used = 1'b0;
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                dat = model_rd(s + 32'(4 * i));
                t.addr = s + 32'(4 * i); t.data = 32'd0; t.wr = 1'b0;
                exp_q.push_back(t);
                t.addr = d + 32'(4 * i); t.data = dat; t.wr = 1'b1;
                exp_q.push_back(t);
                model_mem[d + 32'(4 * i)] = dat;
            end
        end
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = LEN_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        in_copy = 1'b1;
        start_cyc = cyc;
    endtask

    // poke > 0 pulses a stray start that many cycles into the copy.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int mode, input int poke);
        prep(s, d, n, mode);
        pulse_start(s, d, n);
        for (int k = 0; k < 120 * n + 100 && in_copy; k++) begin
            @(negedge clk);
            if (poke > 0 && k == poke) begin
                start = 1'b1; src_addr = 32'h40; dst_addr = 32'h80; len = LEN_W'(5);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (in_copy) begin
            check("done_timeout", 32'(in_copy), 32'd0);
            in_copy = 1'b0;
            exp_q.delete();
        end
    endtask

    initial begin
        int t0;
        logic [31:0] s, d;
        #12;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Three-word copy with one-cycle memory response.
        bus_mem[32'h100] = 32'hAAAA_0001; model_mem[32'h100] = 32'hAAAA_0001;
        bus_mem[32'h104] = 32'hBBBB_0002; model_mem[32'h104] = 32'hBBBB_0002;
        bus_mem[32'h108] = 32'hCCCC_0003; model_mem[32'h108] = 32'hCCCC_0003;
        run_copy(32'h100, 32'h200, 3, 0, 0);
        check("copy3_w0", bus_rd(32'h200), 32'hAAAA_0001);
        check("copy3_w1", bus_rd(32'h204), 32'hBBBB_0002);
        check("copy3_w2", bus_rd(32'h208), 32'hCCCC_0003);
        check("copy3_count", 32'(count_obs), 32'd3);
        check("copy3_cycles", 32'(done_lat_obs), 32'd20);
        check("copy3_err", 32'(err_obs), 32'd0);

        // Zero-length request: done only, no bus activity.
        t0 = txn_cnt;
        run_copy(32'h300, 32'h400, 0, 0, 0);
        check("len0_cycles", 32'(done_lat_obs), 32'd2);
        check("len0_count", 32'(count_obs), 32'd0);
        check("len0_no_bus", 32'(txn_cnt - t0), 32'd0);

        // Misaligned source: done with err, no bus activity.
        t0 = txn_cnt;
        run_copy(32'h102, 32'h200, 4, 0, 0);
        check("misalign_err", 32'(err_obs), 32'd1);
        check("misalign_no_bus", 32'(txn_cnt - t0), 32'd0);

        // 50-cycle stall on the first write; held fields are compared every cycle.
        run_copy(32'h500, 32'h600, 2, 2, 0);
        check("stall_w0", bus_rd(32'h600), init_word(32'h500));
        check("stall_w1", bus_rd(32'h604), init_word(32'h504));
        check("stall_count", 32'(count_obs), 32'd2);

        // Source address wraps past the top of the address space.
        rd_log.delete();
        run_copy(32'hFFFF_FFFC, 32'h700, 2, 0, 0);
        check("wrap_rd0", (rd_log.size() > 0) ? rd_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_rd1", (rd_log.size() > 1) ? rd_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Asynchronous reset in the middle of a read.
        prep(32'h800, 32'h900, 4, 0);
        pulse_start(32'h800, 32'h900, 4);
        @(negedge clk);
        #2;
        check("pre_rst_valid", 32'(mem_valid), 32'd1);
        check("pre_rst_wstrb", 32'(mem_wstrb), 32'd0);
        resetn = 1'b0;
        #1;
        check("async_rst_valid", 32'(mem_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        exp_q.delete();
        in_copy = 1'b0;
        for (int i = 0; i < 4; i++) model_mem[32'h900 + 32'(4 * i)] = bus_rd(32'h900 + 32'(4 * i));
        @(negedge clk);
        resetn = 1'b1;
        // Single-word copy right after reset, with a stray start while busy.
        run_copy(32'hA00, 32'hB00, 1, 0, 3);
        check("post_rst_w0", bus_rd(32'hB00), init_word(32'hA00));
        check("post_rst_cycles", 32'(done_lat_obs), 32'd8);

        // Randomized copies, some zero-length or misaligned, fixed or random latency.
        for (int it = 0; it < 12; it++) begin
            s = 32'h1000 + 32'($urandom_range(0, 63) * 4);
            d = 32'h1100 + 32'($urandom_range(0, 63) * 4);
            if (it % 5 == 4) s = s | 32'd1;
            if (it % 7 == 6) d = d | 32'd2;
            run_copy(s, d, $urandom_range(0, 6), $urandom_range(0, 1), 0);
        end
        for (int i = 0; i < 128; i++) begin
            check("final_mem", bus_rd(32'h1000 + 32'(4 * i)), model_rd(32'h1000 + 32'(4 * i)));
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
